// File: rtl/execute_stage.sv
// Execute stage: ALU, load/store address generation, iterative 32-cycle unsigned MULTU/DIVU with HI/LO, EX/MEM register.
// Latency: ALU/address ops 1 cycle; MULTU/DIVU hold busy for 32 cycles after acceptance, HI/LO final on the 32nd edge.
// Backpressure: stall_out (combinational) holds the front end while a HI/LO consumer meets a busy unit; EX/MEM takes a bubble meanwhile.
//
// Ports:
//   CLK, RESET (async, active-low)
//   valid_in, opA_in, opB_in, storeData_in, ALU_control_in, writeRegister_in, Instr_in,
//   do_writeback_in, MemRead_in, MemWrite_in, MemtoReg_in, ALUSrc_in    - ID/EX inputs
//   stall_out                                                          - upstream hold
//   aluResult1, readDataB1, Instr1, ALU_control1, writeRegister1,
//   do_writeback1, MemRead1, MemWrite1, MemtoReg1, ALUSrc1             - EX/MEM register
//   busy                                                               - mul/div iterating
module execute_stage (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        valid_in,
  input  logic [31:0] opA_in,
  input  logic [31:0] opB_in,
  input  logic [31:0] storeData_in,
  input  logic [5:0]  ALU_control_in,
  input  logic [4:0]  writeRegister_in,
  input  logic        do_writeback_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        MemtoReg_in,
  input  logic        ALUSrc_in,
  input  logic [31:0] Instr_in,
  output logic        stall_out,
  output logic [31:0] aluResult1,
  output logic [31:0] readDataB1,
  output logic [31:0] Instr1,
  output logic [5:0]  ALU_control1,
  output logic [4:0]  writeRegister1,
  output logic        do_writeback1,
  output logic        MemRead1,
  output logic        MemWrite1,
  output logic        MemtoReg1,
  output logic        ALUSrc1,
  output logic        busy
);

  localparam logic [5:0] C_ADD   = 6'b000001;
  localparam logic [5:0] C_SUB   = 6'b000010;
  localparam logic [5:0] C_AND   = 6'b000011;
  localparam logic [5:0] C_OR    = 6'b000100;
  localparam logic [5:0] C_XOR   = 6'b000101;
  localparam logic [5:0] C_SLT   = 6'b000110;
  localparam logic [5:0] C_SLL   = 6'b000111;
  localparam logic [5:0] C_SRL   = 6'b001000;
  localparam logic [5:0] C_MULTU = 6'b001001;
  localparam logic [5:0] C_DIVU  = 6'b001010;
  localparam logic [5:0] C_MFHI  = 6'b001011;
  localparam logic [5:0] C_MFLO  = 6'b001100;

  // Mul/div state. During iteration HI/LO double as the working registers:
  //   MULTU: {HI,LO} = {partial product, remaining multiplier bits}
  //   DIVU : {HI,LO} = {partial remainder, remaining dividend / quotient bits}
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_operand;   // multiplicand for MULTU, divisor for DIVU
  logic        r_is_div;
  logic        r_busy;
  logic [4:0]  r_cnt;

  logic        w_is_muldiv;
  logic        w_is_hilo;
  logic        w_accept;
  logic        w_bubble;
  logic [31:0] w_alu;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_sh;
  logic        w_div_ok;
  logic [31:0] w_div_rem;

  assign w_is_muldiv = (ALU_control_in == C_MULTU) || (ALU_control_in == C_DIVU);
  assign w_is_hilo   = w_is_muldiv || (ALU_control_in == C_MFHI) || (ALU_control_in == C_MFLO);

  assign stall_out = valid_in & r_busy & w_is_hilo;
  assign w_accept  = valid_in & ~r_busy & w_is_muldiv;
  assign w_bubble  = ~valid_in | stall_out;
  assign busy      = r_busy;

  // Shift-add step: add multiplicand when the current multiplier bit is set,
  // then shift the whole 65-bit {carry,HI,LO} right by one.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_operand} : 33'd0);

  // Restoring step: shift next dividend bit into the remainder and subtract
  // if it fits. The partial remainder stays below the divisor, so the
  // shifted value fits 33 bits and a successful difference fits 32 bits.
  // With a zero divisor every step "fits", which naturally yields
  // LO = all ones and HI = dividend after 32 steps.
  assign w_div_sh  = {r_hi, r_lo[31]};
  assign w_div_ok  = (w_div_sh >= {1'b0, r_operand});
  assign w_div_rem = w_div_sh[31:0] - r_operand;

  always_comb begin
    w_alu = opA_in + opB_in;  // load/store address and any unlisted code
    case (ALU_control_in)
      C_ADD:   w_alu = opA_in + opB_in;
      C_SUB:   w_alu = opA_in - opB_in;
      C_AND:   w_alu = opA_in & opB_in;
      C_OR:    w_alu = opA_in | opB_in;
      C_XOR:   w_alu = opA_in ^ opB_in;
      C_SLT:   w_alu = {31'd0, ($signed(opA_in) < $signed(opB_in))};
      C_SLL:   w_alu = opA_in << opB_in[4:0];
      C_SRL:   w_alu = opA_in >> opB_in[4:0];
      C_MULTU: w_alu = 32'd0;
      C_DIVU:  w_alu = 32'd0;
      C_MFHI:  w_alu = r_hi;
      C_MFLO:  w_alu = r_lo;
      default: w_alu = opA_in + opB_in;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_operand <= 32'd0;
      r_is_div  <= 1'b0;
      r_busy    <= 1'b0;
      r_cnt     <= 5'd0;
    end else if (r_busy) begin
      if (r_is_div) begin
        r_hi <= w_div_ok ? w_div_rem : w_div_sh[31:0];
        r_lo <= {r_lo[30:0], w_div_ok};
      end else begin
        {r_hi, r_lo} <= {w_mul_sum, r_lo[31:1]};
      end
      r_cnt <= r_cnt + 5'd1;
      // 32nd step completes on this edge
      if (r_cnt == 5'd31) begin
        r_busy <= 1'b0;
      end
    end else if (w_accept) begin
      r_busy    <= 1'b1;
      r_cnt     <= 5'd0;
      r_is_div  <= (ALU_control_in == C_DIVU);
      r_hi      <= 32'd0;
      r_lo      <= (ALU_control_in == C_DIVU) ? opA_in : opB_in;
      r_operand <= (ALU_control_in == C_DIVU) ? opB_in : opA_in;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      aluResult1     <= 32'd0;
      readDataB1     <= 32'd0;
      Instr1         <= 32'd0;
      ALU_control1   <= 6'd0;
      writeRegister1 <= 5'd0;
      do_writeback1  <= 1'b0;
      MemRead1       <= 1'b0;
      MemWrite1      <= 1'b0;
      MemtoReg1      <= 1'b0;
      ALUSrc1        <= 1'b0;
    end else if (w_bubble) begin
      aluResult1     <= 32'd0;
      readDataB1     <= 32'd0;
      Instr1         <= 32'd0;
      ALU_control1   <= 6'd0;
      writeRegister1 <= 5'd0;
      do_writeback1  <= 1'b0;
      MemRead1       <= 1'b0;
      MemWrite1      <= 1'b0;
      MemtoReg1      <= 1'b0;
      ALUSrc1        <= 1'b0;
    end else begin
      aluResult1     <= w_alu;
      readDataB1     <= storeData_in;
      Instr1         <= Instr_in;
      ALU_control1   <= ALU_control_in;
      writeRegister1 <= writeRegister_in;
      // an accepted MULTU/DIVU retires without writing a register
      do_writeback1  <= do_writeback_in & ~w_is_muldiv;
      MemRead1       <= MemRead_in;
      MemWrite1      <= MemWrite_in;
      MemtoReg1      <= MemtoReg_in;
      ALUSrc1        <= ALUSrc_in;
    end
  end

endmodule
